completion_arbiter: RTL

COMPLETION_ARBITER -- requirements
Module: completion_arbiter

---
 rtl/completion_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/completion_arbiter.sv
// Completion arbiter: each execution unit owns a small FIFO of completion
// messages. A round-robin arbiter drains the FIFOs into one registered output
// stage that feeds the register file complete port.
module completion_arbiter #(
  parameter int N_REQ = 3,
  parameter int DEPTH = 2
) (
  input  logic                clock,
  input  logic                nreset,
  input  logic                flash,
  input  logic [N_REQ-1:0]    req_en,
  input  logic [N_REQ*8-1:0]  req_dest_logic,
  input  logic [N_REQ*64-1:0] req_dest_phys,
  input  logic [N_REQ*32-1:0] req_data,
  output logic [N_REQ-1:0]    req_reject,
  output logic                out_en,
  output logic [7:0]          out_dest_logic,
  output logic [63:0]         out_dest_phys,
  output logic [31:0]         out_data,
  input  logic                out_reject
);

  localparam int SEL_W = $clog2(N_REQ);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [SEL_W:0] N_W  = (SEL_W + 1)'(N_REQ);
  localparam logic [CW-1:0]  FULL = CW'(DEPTH);

  typedef struct packed {
    logic [7:0]  dest_logic;
    logic [63:0] dest_phys;
    logic [31:0] data;
  } entry_t;

  entry_t           mem    [N_REQ][DEPTH];
  logic [AW-1:0]    wr_ptr [N_REQ];
  logic [AW-1:0]    rd_ptr [N_REQ];
  logic [CW-1:0]    count  [N_REQ];
  logic [SEL_W-1:0] rr_ptr;

  logic [N_REQ-1:0] push;
  logic [N_REQ-1:0] pop;
  logic             stage_free;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W-1:0] rr_next;
  logic [SEL_W:0]   cand_sum;
  logic [SEL_W:0]   rr_sum;

  // The output stage can take a new message when empty or being consumed.
  assign stage_free = !out_en || !out_reject;

  // Back-pressure from registered occupancy; push/pop qualification.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    req_reject = '0;
    push       = '0;
    pop        = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_reject[i] = (count[i] == FULL);
      push[i]       = req_en[i] && !req_reject[i] && !flash;
      pop[i]        = grant_vld && stage_free && !flash && (grant_idx == SEL_W'(i));
    end
  end

  // Round-robin search from rr_ptr upward with wrap; also next pointer value.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand_sum  = '0;
    rr_sum    = '0;
    rr_next   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_sum = {1'b0, rr_ptr} + (SEL_W + 1)'(k);
      if (cand_sum >= N_W) cand_sum = cand_sum - N_W;
      if (!grant_vld && count[cand_sum[SEL_W-1:0]] != '0) begin
        grant_vld = 1'b1;
        grant_idx = cand_sum[SEL_W-1:0];
      end
    end
    rr_sum = {1'b0, grant_idx} + 1'b1;
    if (rr_sum >= N_W) rr_sum = rr_sum - N_W;
    rr_next = rr_sum[SEL_W-1:0];
  end

  // FIFO bookkeeping: pointers wrap naturally, count tracks push minus pop.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < N_REQ; i++) begin
        // NOTE: sequential state is updated with non-blocking assignments only, so every flop sees pre-edge values.
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else if (flash) begin
      for (int i = 0; i < N_REQ; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // Entry storage write port.
  always_ff @(posedge clock) begin
    // NOTE: storage is not reset; occupancy counts alone decide which entries are valid.
    for (int i = 0; i < N_REQ; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= '{dest_logic: req_dest_logic[i*8 +: 8],
                               dest_phys:  req_dest_phys[i*64 +: 64],
                               data:       req_data[i*32 +: 32]};
      end
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      out_en         <= 1'b0;
      out_dest_logic <= '0;
      out_dest_phys  <= '0;
      out_data       <= '0;
      rr_ptr         <= '0;
    end else if (flash) begin
      out_en         <= 1'b0;
      out_dest_logic <= '0;
      out_dest_phys  <= '0;
      out_data       <= '0;
      rr_ptr         <= '0;
    end else if (stage_free) begin
      if (grant_vld) begin
        out_en         <= 1'b1;
        out_dest_logic <= mem[grant_idx][rd_ptr[grant_idx]].dest_logic;
        out_dest_phys  <= mem[grant_idx][rd_ptr[grant_idx]].dest_phys;
        out_data       <= mem[grant_idx][rd_ptr[grant_idx]].data;
        rr_ptr         <= rr_next;
      end else begin
        out_en <= 1'b0;
      end
    end
  end

endmodule
